// File: rtl/program_loader.sv
// program_loader: boot-time frame receiver that fills program memory with
// 16-bit words and releases the CPU only after a frame's checksum matches.
// Frame: SYNC, LEN_HI, LEN_LO, LEN x {word_hi, word_lo}, CHK.
// MAX_WORDS must not exceed 65535, so the 16-bit word counter never wraps.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        restart,
  output logic        prog_we,
  output logic [15:0] prog_addr,
  output logic [15:0] prog_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error_code,
  output logic [15:0] word_count
);

  // Timer is at least 17 bits wide so the default 100000-cycle limit fits.
  localparam int unsigned TMR_W = ($clog2(TIMEOUT_CYCLES) > 17) ? $clog2(TIMEOUT_CYCLES) : 17;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      MAX_LEN  = 16'(MAX_WORDS);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_CHECK   = 4'd5,
    S_EVAL    = 4'd6,
    S_RUN     = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  state_t            state_q,      state_d;
  logic [7:0]        len_hi_q,     len_hi_d;
  logic [15:0]       len_q,        len_d;
  logic [7:0]        data_hi_q,    data_hi_d;
  logic [7:0]        acc_q,        acc_d;
  logic [7:0]        rx_chk_q,     rx_chk_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              prog_we_q,    prog_we_d;
  logic [15:0]       prog_addr_q,  prog_addr_d;
  logic [15:0]       prog_wdata_q, prog_wdata_d;
  logic              cpu_run_q,    cpu_run_d;
  logic              done_q,       done_d;
  logic              busy_q,       busy_d;
  logic [1:0]        err_q,        err_d;

  logic              ready_int;
  logic              accept;
  logic              in_frame;
  logic [15:0]       len_rx;
  logic [15:0]       word_count_inc;

  // The loader takes bytes in every state except EVAL, RUN and ERROR.
  assign ready_int = (state_q == S_IDLE)    || (state_q == S_LEN_HI)  ||
                     (state_q == S_LEN_LO)  || (state_q == S_DATA_HI) ||
                     (state_q == S_DATA_LO) || (state_q == S_CHECK);
  assign accept    = in_valid && ready_int;

  // States in which the inter-byte idle timer runs.
  assign in_frame  = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                     (state_q == S_CHECK);

  assign len_rx         = {len_hi_q, in_data};
  assign word_count_inc = word_count_q + 16'd1;

  // Next-state and datapath: restart wins, then the per-state byte handling,
  // then the idle timeout (which only fires when no byte arrives).
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    data_hi_d    = data_hi_q;
    acc_d        = acc_q;
    rx_chk_d     = rx_chk_q;
    timer_d      = timer_q;
    word_count_d = word_count_q;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_wdata_d = prog_wdata_q;
    cpu_run_d    = cpu_run_q;
    done_d       = done_q;
    busy_d       = busy_q;
    err_d        = err_q;

    if (restart) begin
      // Any byte offered this cycle is dropped.
      state_d   = S_IDLE;
      cpu_run_d = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      err_d     = ERR_NONE;
      timer_d   = '0;
    end else begin
      // Timer clears on every accepted byte and idles at zero outside a frame.
      if (accept || !in_frame) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            acc_d        = 8'h00;
            word_count_d = 16'd0;
            err_d        = ERR_NONE;
            busy_d       = 1'b1;
            state_d      = S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_hi_d = in_data;
            acc_d    = acc_q ^ in_data;
            state_d  = S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_d = len_rx;
            acc_d = acc_q ^ in_data;
            if ((len_rx == 16'd0) || (len_rx > MAX_LEN)) begin
              err_d   = ERR_LEN;
              busy_d  = 1'b0;
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA_HI;
            end
          end
        end

        S_DATA_HI: begin
          if (accept) begin
            data_hi_d = in_data;
            acc_d     = acc_q ^ in_data;
            state_d   = S_DATA_LO;
          end
        end

        S_DATA_LO: begin
          if (accept) begin
            acc_d        = acc_q ^ in_data;
            prog_we_d    = 1'b1;
            prog_addr_d  = word_count_q;
            prog_wdata_d = {data_hi_q, in_data};
            word_count_d = word_count_inc;
            state_d      = (word_count_inc == len_q) ? S_CHECK : S_DATA_HI;
          end
        end

        S_CHECK: begin
          if (accept) begin
            rx_chk_d = in_data;
            state_d  = S_EVAL;
          end
        end

        S_EVAL: begin
          busy_d = 1'b0;
          if (rx_chk_q == acc_q) begin
            cpu_run_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_RUN;
          end else begin
            err_d   = ERR_CHK;
            state_d = S_ERROR;
          end
        end

        S_RUN: begin
          state_d = S_RUN;
        end

        S_ERROR: begin
          state_d = S_ERROR;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // A stalled frame aborts once the idle count reaches its limit.
      if (in_frame && !accept && (timer_q == TMR_LAST)) begin
        err_d   = ERR_TIMEOUT;
        busy_d  = 1'b0;
        state_d = S_ERROR;
      end
    end
  end

  // State and datapath registers; reset also cancels a pending write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_hi_q     <= 8'h00;
      len_q        <= 16'd0;
      data_hi_q    <= 8'h00;
      acc_q        <= 8'h00;
      rx_chk_q     <= 8'h00;
      timer_q      <= '0;
      word_count_q <= 16'd0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= 16'd0;
      prog_wdata_q <= 16'd0;
      cpu_run_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      data_hi_q    <= data_hi_d;
      acc_q        <= acc_d;
      rx_chk_q     <= rx_chk_d;
      timer_q      <= timer_d;
      word_count_q <= word_count_d;
      prog_we_q    <= prog_we_d;
      prog_addr_q  <= prog_addr_d;
      prog_wdata_q <= prog_wdata_d;
      cpu_run_q    <= cpu_run_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = ready_int;
  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wdata = prog_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error_code = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (MAX_WORDS = 256, TIMEOUT_CYCLES = 16).
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        prog_we;
  logic [15:0] prog_addr;
  logic [15:0] prog_wdata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic [1:0]  error_code;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  // Write log captured by the monitor.
  int          wr_cnt = 0;
  logic [15:0] wr_addr [8];
  logic [15:0] wr_data [8];

  program_loader #(
    .SYNC_BYTE      (8'hA5),
    .MAX_WORDS      (256),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .restart    (restart),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .error_code (error_code),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every program memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = prog_addr;
        wr_data[wr_cnt] = prog_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte, optionally after an idle cycle; bounded wait for ready.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("handshake", {15'd0, ok}, 16'd1);
    $display("tb: sent byte %h accepted=%0d", b, ok);
  endtask

  // Two-word frame A5 00 02 12 34 AB CD <chkb>.
  task automatic send_frame(input logic [7:0] chkb, input bit gap);
    logic [7:0] frm [7];
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    for (int i = 0; i < 7; i++) send_byte(frm[i], gap);
    send_byte(chkb, gap);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_wr_cnt"}, 16'(wr_cnt), 16'd2);
    chk({tag, "_addr0"}, wr_addr[0], 16'h0000);
    chk({tag, "_data0"}, wr_data[0], 16'h1234);
    chk({tag, "_addr1"}, wr_addr[1], 16'h0001);
    chk({tag, "_data1"}, wr_data[1], 16'hABCD);
  endtask

  initial begin
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    restart  = 1'b0;
    step();
    step();

    // Reset values.
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_error", {14'd0, error_code}, 16'd0);
    chk("rst_word_count", word_count, 16'd0);
    chk("rst_prog_we", {15'd0, prog_we}, 16'd0);
    chk("rst_prog_addr", prog_addr, 16'd0);
    rst = 1'b1;
    step();

    // Good frame: CHK = 0x42.
    wr_cnt = 0;
    send_byte(8'hA5, 1'b0);
    chk("good_busy_after_sync", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] body [6];
      body = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      send_byte(body[i], 1'b0);
    end
    send_byte(8'h42, 1'b0);
    chk("good_eval_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("good_eval_in_ready", {15'd0, in_ready}, 16'd0);
    chk("good_eval_busy", {15'd0, busy}, 16'd1);
    step();
    chk("good_cpu_run", {15'd0, cpu_run}, 16'd1);
    chk("good_done", {15'd0, done}, 16'd1);
    chk("good_busy", {15'd0, busy}, 16'd0);
    chk("good_error", {14'd0, error_code}, 16'd0);
    chk("good_word_count", word_count, 16'd2);
    chk("good_in_ready", {15'd0, in_ready}, 16'd0);
    chk("good_addr_hold", prog_addr, 16'h0001);
    chk("good_wdata_hold", prog_wdata, 16'hABCD);
    check_two_writes("good");

    // Restart out of RUN.
    pulse_restart();
    chk("restart_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("restart_done", {15'd0, done}, 16'd0);
    chk("restart_in_ready", {15'd0, in_ready}, 16'd1);

    // Bad checksum: writes still happen, error 10, stuck until restart.
    wr_cnt = 0;
    send_frame(8'h43, 1'b0);
    step();
    chk("badchk_error", {14'd0, error_code}, 16'd2);
    chk("badchk_cpu_run", {15'd0, cpu_run}, 16'd0);
    chk("badchk_busy", {15'd0, busy}, 16'd0);
    step();
    step();
    chk("badchk_in_ready", {15'd0, in_ready}, 16'd0);
    check_two_writes("badchk");
    pulse_restart();
    chk("badchk_restart_error", {14'd0, error_code}, 16'd0);
    chk("badchk_restart_ready", {15'd0, in_ready}, 16'd1);

    // Length zero.
    wr_cnt = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len0_error", {14'd0, error_code}, 16'd1);
    chk("len0_busy", {15'd0, busy}, 16'd0);
    step();
    chk("len0_writes", 16'(wr_cnt), 16'd0);
    pulse_restart();

    // Length 257 exceeds 256.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("len257_error", {14'd0, error_code}, 16'd1);
    step();
    chk("len257_writes", 16'(wr_cnt), 16'd0);
    pulse_restart();

    // Length 256 is the largest legal value.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len256_error", {14'd0, error_code}, 16'd0);
    chk("len256_busy", {15'd0, busy}, 16'd1);
    pulse_restart();
    chk("len256_restart_busy", {15'd0, busy}, 16'd0);

    // Noise bytes, then the good frame with in_valid on alternate cycles.
    wr_cnt = 0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("noise_busy", {15'd0, busy}, 16'd0);
    send_frame(8'h42, 1'b1);
    step();
    chk("bp_cpu_run", {15'd0, cpu_run}, 16'd1);
    chk("bp_word_count", word_count, 16'd2);
    check_two_writes("bp");
    pulse_restart();

    // Timeout: one word expected, only its high byte arrives.
    wr_cnt = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("timeout_not_yet", {14'd0, error_code}, 16'd0);
    step();
    chk("timeout_error", {14'd0, error_code}, 16'd3);
    chk("timeout_busy", {15'd0, busy}, 16'd0);
    chk("timeout_writes", 16'(wr_cnt), 16'd0);
    pulse_restart();
    chk("timeout_restart_error", {14'd0, error_code}, 16'd0);
    chk("timeout_restart_ready", {15'd0, in_ready}, 16'd1);

    // Reset mid-frame: one word written, then reset while a low byte is offered.
    wr_cnt = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    chk("midrst_pre_word_count", word_count, 16'd1);
    send_byte(8'h9A, 1'b0);
    in_data  = 8'hBC;
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("midrst_word_count", word_count, 16'd0);
    chk("midrst_prog_addr", prog_addr, 16'd0);
    chk("midrst_prog_wdata", prog_wdata, 16'd0);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    chk("midrst_writes", 16'(wr_cnt), 16'd1);
    rst = 1'b1;
    step();

    // Reload after reset.
    wr_cnt = 0;
    send_frame(8'h42, 1'b0);
    step();
    chk("reload_cpu_run", {15'd0, cpu_run}, 16'd1);
    check_two_writes("reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader sitting directly upstream of the CPU core. It receives a framed byte stream over a valid/ready interface, assembles 16-bit instruction words, and writes them sequentially into program memory from address 0. It holds the CPU stopped until a complete frame passes its checksum, then asserts cpu_run. Frame format: SYNC, LEN_HI, LEN_LO, then LEN words sent as high byte then low byte, then CHK.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_WORDS, 256, program memory depth in words; a LEN above this is rejected.
TIMEOUT_CYCLES, 100000, maximum idle cycles between accepted bytes inside a frame; width is at least 17 bits.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-low reset.
in_data  input  8  received byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a byte.
restart  input  1  single-cycle request to abort or leave RUN/ERROR and return to IDLE.
prog_we  output  1  program memory write strobe, 1 cycle.
prog_addr  output  16  program memory write address, in words.
prog_wdata  output  16  instruction word written as {hi, lo}.
cpu_run  output  1  1 = CPU released; 0 = CPU held.
busy  output  1  frame in progress, from after SYNC until CHK is evaluated.
done  output  1  last frame loaded successfully.
error_code  output  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout.
word_count  output  16  number of words written in the current or last frame.

Behaviour:
- Reset values: all outputs 0 except in_ready = 1. State is IDLE and the checksum accumulator is 0x00.
- Handshake: a byte is accepted on a rising edge where in_valid and in_ready are both 1. in_ready = 1 in IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. in_ready = 0 in EVAL, RUN and ERROR.
- State machine:
  - IDLE: a byte other than SYNC_BYTE is discarded. SYNC_BYTE clears the accumulator, word_count and error_code, sets busy, and goes to LEN_HI.
  - LEN_HI then LEN_LO: latch LEN = {hi, lo}. If LEN == 0 or LEN > MAX_WORDS, go to ERROR with code 01. Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, then go to DATA_LO.
  - DATA_LO: on accept, in the next cycle prog_we = 1, prog_addr = word_count (old value), prog_wdata = {hi, lo}, and word_count increments. When the new word_count equals LEN, go to CHECK; otherwise go to DATA_HI.
  - CHECK: accept the CHK byte, then go to EVAL (1 cycle). If CHK equals the accumulator, go to RUN; otherwise go to ERROR with code 10.
  - RUN: cpu_run = 1 and done = 1, asserted the cycle after EVAL. busy = 0.
  - ERROR: cpu_run = 0, busy = 0, error_code holds.
- Checksum: the accumulator is the XOR of every accepted byte after SYNC, including LEN_HI and LEN_LO, and excluding CHK.
- Write latency: prog_we is registered, one cycle after the DATA_LO accept. prog_addr and prog_wdata hold their values when prog_we = 0.
- Timeout: a counter clears on every accepted byte and on entering LEN_HI. It increments every cycle in LEN_HI through CHECK. When it reaches TIMEOUT_CYCLES - 1, go to ERROR with code 11. No timeout applies in IDLE.
- restart: honoured in any state. The next state is IDLE, and cpu_run, done, busy and error_code clear. restart takes priority over a byte accepted in the same cycle; that byte is dropped.
- Program memory contents written before an error are not rolled back; cpu_run stays 0.
- Reset mid-frame: immediate return to reset values. A prog_we pulse in flight is cancelled.
- word_count wraps only if MAX_WORDS ≥ 65536. This is not allowed: MAX_WORDS must be ≤ 65535.

Test Plan:
- Good frame: A5 00 02 12 34 AB CD, CHK = 00^02^12^34^AB^CD = 0x42 → writes (0,0x1234) and (1,0xABCD); cpu_run = 1 and done = 1 two cycles after CHK accept; word_count = 2.
- Bad checksum: same frame with CHK = 0x43 → both writes occur; error_code = 10; cpu_run stays 0; in_ready = 0 until restart.
- Length bounds: A5 00 00 → error_code = 01. A5 01 01 with MAX_WORDS = 256 → error_code = 01. Neither case produces any prog_we.
- Noise and backpressure: bytes 00 FF then the good frame, with in_valid toggling every other cycle → the leading bytes are ignored and results are identical to the good frame.
- Timeout: with TIMEOUT_CYCLES = 16, send A5 00 01 12, then stall → error_code = 11 exactly 16 cycles after the last accept; one prog_we has not occurred; a restart pulse returns to IDLE.
- Reset and restart: assert rst low mid-DATA_LO → all outputs return to reset values; restart in RUN → cpu_run drops the next cycle and a new frame reloads correctly.
